// File: rtl/cpu_stack_seq.sv
// SM83 stack-operation sequencer: owns SP and runs the M2..M4 bus cycles of POP/PUSH/RET/CALL-push.
// Define CPU_STACK_SEQ_FORMAL_EN to compile in the embedded immediate assertions.
module cpu_stack_seq #(
  parameter logic [15:0] SP_RESET = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic        is_af,
  input  logic [15:0] src16,
  input  logic        sp_wr,
  input  logic [15:0] sp_wdata,
  input  logic [7:0]  din,
  output logic [15:0] sp,
  output logic [15:0] adr,
  output logic        rd,
  output logic        wr,
  output logic [7:0]  dout,
  output logic        wb_valid,
  output logic [15:0] wb_data,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INT   = 3'd1,
    S_RD_LO = 3'd2,
    S_RD_HI = 3'd3,
    S_WR_HI = 3'd4,
    S_WR_LO = 3'd5,
    S_TAIL  = 3'd6
  } state_t;

  localparam logic [1:0] OP_POP  = 2'd0;
  localparam logic [1:0] OP_PUSH = 2'd1;
  localparam logic [1:0] OP_RET  = 2'd2;

  state_t      state_r, state_s;
  logic [1:0]  t_r, t_s;
  logic [1:0]  op_r;
  logic        af_r;
  logic [15:0] src_r, sp_r, adr_r, wb_data_r;
  logic [7:0]  lo_r, dout_r;
  logic        rd_r, wr_r, busy_r, done_r, wb_valid_r;
  logic        accept_s, done_s;

  function automatic state_t first_state(input logic [1:0] o);
    case (o)
      OP_POP:  first_state = S_RD_LO;
      OP_RET:  first_state = S_RD_LO;
      default: first_state = S_INT;
    endcase
  endfunction

  function automatic logic is_last(input state_t s, input logic [1:0] o);
    case (s)
      S_RD_HI: is_last = (o == OP_POP);
      S_WR_LO: is_last = 1'b1;
      S_TAIL:  is_last = 1'b1;
      default: is_last = 1'b0;
    endcase
  endfunction

  // Next state / T-counter; a new start is taken in IDLE or in the final T4 of a sequence.
  always_comb begin
    state_s  = state_r;
    t_s      = t_r;
    accept_s = 1'b0;
    if (state_r == S_IDLE) begin
      if (start && !sp_wr) begin
        accept_s = 1'b1;
        state_s  = first_state(op);
        t_s      = 2'd0;
      end else begin
        state_s = S_IDLE;
      end
    end else begin
      t_s = t_r + 2'd1;
      if (t_r == 2'd3) begin
        if (is_last(state_r, op_r)) begin
          if (start) begin
            accept_s = 1'b1;
            state_s  = first_state(op);
          end else begin
            state_s = S_IDLE;
          end
        end else begin
          case (state_r)
            S_INT:   state_s = S_WR_HI;
            S_WR_HI: state_s = S_WR_LO;
            S_RD_LO: state_s = S_RD_HI;
            S_RD_HI: state_s = S_TAIL;
            default: state_s = S_IDLE;
          endcase
        end
      end else begin
        state_s = state_r;
      end
    end
  end

  // Final-T4 indicator for the cycle being entered.
  always_comb begin
    if (state_s != S_IDLE && t_s == 2'd3) begin
      done_s = is_last(state_s, op_r);
    end else begin
      done_s = 1'b0;
    end
  end

  // Sequencer state, latched operands and stack pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
      t_r     <= 2'd0;
      op_r    <= 2'd0;
      af_r    <= 1'b0;
      src_r   <= 16'h0000;
      sp_r    <= SP_RESET;
    end else begin
      state_r <= state_s;
      t_r     <= t_s;
      if (accept_s) begin
        op_r  <= op;
        af_r  <= is_af;
        src_r <= src16;
      end
      if (state_r == S_IDLE && sp_wr) begin
        sp_r <= sp_wdata;
      end else if (t_r == 2'd0) begin
        case (state_r)
          S_RD_LO, S_RD_HI: sp_r <= sp_r + 16'd1;
          S_INT, S_WR_HI:   sp_r <= sp_r - 16'd1;
          default:          sp_r <= sp_r;
        endcase
      end
    end
  end

  // Registered bus outputs, read capture and writeback.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      adr_r      <= 16'h0000;
      dout_r     <= 8'h00;
      lo_r       <= 8'h00;
      wb_data_r  <= 16'h0000;
      rd_r       <= 1'b0;
      wr_r       <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      wb_valid_r <= 1'b0;
    end else begin
      if (t_s == 2'd0 && (state_s == S_RD_LO || state_s == S_RD_HI ||
                          state_s == S_WR_HI || state_s == S_WR_LO)) begin
        adr_r <= sp_r;
      end
      if (state_s == S_WR_HI) begin
        dout_r <= src_r[15:8];
      end else if (state_s == S_WR_LO) begin
        dout_r <= src_r[7:0];
      end
      if (state_r == S_RD_LO && t_r == 2'd2) begin
        lo_r <= din;
      end
      // F[3:0] reads back as zero on POP AF.
      if (state_r == S_RD_HI && t_r == 2'd2) begin
        wb_data_r <= {din, lo_r[7:4], (op_r == OP_POP && af_r) ? 4'h0 : lo_r[3:0]};
      end
      rd_r       <= (state_s == S_RD_LO || state_s == S_RD_HI) && (t_s != 2'd3);
      wr_r       <= (state_s == S_WR_HI || state_s == S_WR_LO) && (t_s == 2'd1 || t_s == 2'd2);
      busy_r     <= (state_s != S_IDLE);
      done_r     <= done_s;
      wb_valid_r <= done_s && (op_r == OP_POP || op_r == OP_RET);
    end
  end

  assign sp       = sp_r;
  assign adr      = adr_r;
  assign rd       = rd_r;
  assign wr       = wr_r;
  assign dout     = dout_r;
  assign wb_valid = wb_valid_r;
  assign wb_data  = wb_data_r;
  assign busy     = busy_r;
  assign done     = done_r;

`ifdef CPU_STACK_SEQ_FORMAL_EN
  logic [15:0] adr_prev_r;
  logic        pending_r;

  // History for the bus-stability and start-before-done properties.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      adr_prev_r <= 16'h0000;
      pending_r  <= 1'b0;
    end else begin
      adr_prev_r <= adr_r;
      if (accept_s) begin
        pending_r <= 1'b1;
      end else if (done_r) begin
        pending_r <= 1'b0;
      end
    end
  end

  // Embedded immediate assertions.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(rd_r && wr_r)) else $error("rd and wr high together");
      assert (busy_r || (!rd_r && !wr_r)) else $error("strobe while idle");
      assert (!done_r || pending_r) else $error("done without start");
      if (t_r != 2'd0 && (state_r == S_RD_LO || state_r == S_RD_HI ||
                          state_r == S_WR_HI || state_r == S_WR_LO)) begin
        assert (adr_r == adr_prev_r) else $error("adr changed inside bus cycle");
      end
    end
  end
`else
  // Default build: no checker logic.
`endif

endmodule

// File: tb/tb_cpu_stack_seq.sv
// Scoreboard bench for cpu_stack_seq: stimulus queues expected bus accesses and completions,
// a negedge monitor pops and compares them as the DUT presents strobes and done.
module tb_cpu_stack_seq;

  localparam logic [1:0] OP_POP  = 2'd0;
  localparam logic [1:0] OP_PUSH = 2'd1;
  localparam logic [1:0] OP_RET  = 2'd2;
  localparam logic [1:0] OP_CALL = 2'd3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic        is_af = 1'b0;
  logic [15:0] src16 = 16'h0000;
  logic        sp_wr = 1'b0;
  logic [15:0] sp_wdata = 16'h0000;
  logic [7:0]  din = 8'h00;
  logic [15:0] sp, adr, wb_data;
  logic        rd, wr, wb_valid, busy, done;
  logic [7:0]  dout;

  cpu_stack_seq #(.SP_RESET(16'h0000)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .is_af(is_af), .src16(src16),
    .sp_wr(sp_wr), .sp_wdata(sp_wdata), .din(din), .sp(sp), .adr(adr), .rd(rd), .wr(wr),
    .dout(dout), .wb_valid(wb_valid), .wb_data(wb_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_wr;
    logic [15:0] adr;
    logic [7:0]  data;
    int          cyc;
  } bus_t;

  typedef struct {
    int          cyc;
    bit          wbv;
    logic [15:0] wb;
    logic [15:0] sp;
  } done_t;

  bus_t        bus_q[$];
  done_t       done_q[$];
  logic [7:0]  mem [0:65535];
  logic [15:0] sp_m = 16'h0000;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  logic        rd_prev = 1'b0;
  logic        wr_prev = 1'b0;
  bus_t        be;
  done_t       de;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory model drives read data; monitor checks every strobe and completion.
  always @(negedge clk) begin
    din = mem[adr];
    if (!reset) begin
      if (rd) chk("rd_wr_excl", {31'd0, wr}, 32'd0);
      if (rd && !rd_prev) begin
        if (bus_q.size() == 0) begin
          chk("unexp_rd", {31'd0, rd}, 32'd0);
        end else begin
          be = bus_q.pop_front();
          chk("acc_kind_rd", 32'd0, {31'd0, be.is_wr});
          chk("rd_adr", {16'd0, adr}, {16'd0, be.adr});
          chk("rd_cyc", cyc, be.cyc);
        end
      end
      if (wr && !wr_prev) begin
        if (bus_q.size() == 0) begin
          chk("unexp_wr", {31'd0, wr}, 32'd0);
        end else begin
          be = bus_q.pop_front();
          chk("acc_kind_wr", 32'd1, {31'd0, be.is_wr});
          chk("wr_adr", {16'd0, adr}, {16'd0, be.adr});
          chk("wr_data", {24'd0, dout}, {24'd0, be.data});
          chk("wr_cyc", cyc, be.cyc);
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          chk("unexp_done", {31'd0, done}, 32'd0);
        end else begin
          de = done_q.pop_front();
          chk("done_cyc", cyc, de.cyc);
          chk("wb_valid", {31'd0, wb_valid}, {31'd0, de.wbv});
          if (de.wbv) chk("wb_data", {16'd0, wb_data}, {16'd0, de.wb});
          chk("sp_at_done", {16'd0, sp}, {16'd0, de.sp});
        end
      end else if (wb_valid) begin
        chk("wb_without_done", {31'd0, wb_valid}, 32'd0);
      end
    end
    rd_prev = rd;
    wr_prev = wr;
  end

  // Called just after a clock edge; start is sampled at the next edge (cycle 0).
  task automatic issue(input logic [1:0] o, input logic af, input logic [15:0] s16);
    int          s;
    logic [15:0] a_lo, a_hi, w;
    bus_t        b;
    done_t       d;
    s = cyc;
    start = 1'b1; op = o; is_af = af; src16 = s16;
    if (o == OP_POP || o == OP_RET) begin
      a_lo = sp_m;
      a_hi = sp_m + 16'd1;
      b = '{is_wr: 1'b0, adr: a_lo, data: 8'h00, cyc: s + 1}; bus_q.push_back(b);
      b = '{is_wr: 1'b0, adr: a_hi, data: 8'h00, cyc: s + 5}; bus_q.push_back(b);
      w = {mem[a_hi], mem[a_lo]};
      if (o == OP_POP && af) w[3:0] = 4'h0;
      sp_m = sp_m + 16'd2;
      d = '{cyc: s + ((o == OP_POP) ? 8 : 12), wbv: 1'b1, wb: w, sp: sp_m};
    end else begin
      a_hi = sp_m - 16'd1;
      a_lo = sp_m - 16'd2;
      b = '{is_wr: 1'b1, adr: a_hi, data: s16[15:8], cyc: s + 6}; bus_q.push_back(b);
      b = '{is_wr: 1'b1, adr: a_lo, data: s16[7:0], cyc: s + 10}; bus_q.push_back(b);
      mem[a_hi] = s16[15:8];
      mem[a_lo] = s16[7:0];
      sp_m = sp_m - 16'd2;
      d = '{cyc: s + 12, wbv: 1'b0, wb: 16'h0000, sp: sp_m};
    end
    done_q.push_back(d);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("idle_timeout", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic sp_load(input logic [15:0] v);
    sp_wr = 1'b1; sp_wdata = v;
    @(posedge clk); #1;
    sp_wr = 1'b0;
    sp_m = v;
    chk("sp_load", {16'd0, sp}, {16'd0, v});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sp", {16'd0, sp}, 32'd0);
    chk("rst_adr", {16'd0, adr}, 32'd0);
    chk("rst_ctrl", {27'd0, rd, wr, busy, done, wb_valid}, 32'd0);
    chk("rst_data", {8'd0, dout, wb_data}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // POP BC and POP AF
    sp_load(16'hC000);
    mem[16'hC000] = 8'h34; mem[16'hC001] = 8'h12;
    mem[16'hC002] = 8'hFF; mem[16'hC003] = 8'hA5;
    issue(OP_POP, 1'b0, 16'h0000); wait_idle();
    chk("pop_bc_sp", {16'd0, sp}, 32'h0000C002);
    issue(OP_POP, 1'b1, 16'h0000); wait_idle();

    // PUSH DE then POP it back
    sp_load(16'hD000);
    issue(OP_PUSH, 1'b0, 16'hBEEF); wait_idle();
    chk("push_sp", {16'd0, sp}, 32'h0000CFFE);
    issue(OP_POP, 1'b0, 16'h0000); wait_idle();

    // Wrap-around in both directions
    sp_load(16'hFFFF);
    mem[16'hFFFF] = 8'h11; mem[16'h0000] = 8'h22;
    issue(OP_POP, 1'b0, 16'h0000); wait_idle();
    chk("wrap_pop_sp", {16'd0, sp}, 32'h00000001);
    issue(OP_CALL, 1'b0, 16'h5678); wait_idle();
    chk("wrap_push_sp", {16'd0, sp}, 32'h0000FFFF);

    // RET then PUSH started in RET's final T4
    sp_load(16'hE000);
    mem[16'hE000] = 8'hCD; mem[16'hE001] = 8'hAB;
    issue(OP_RET, 1'b0, 16'h0000);
    repeat (11) @(posedge clk);
    #1;
    issue(OP_PUSH, 1'b0, 16'h1357);
    for (int i = 1; i < 12; i++) begin
      @(negedge clk);
      chk("b2b_busy", {31'd0, busy}, 32'd1);
    end
    wait_idle();
    chk("b2b_sp", {16'd0, sp}, 32'h0000E000);

    // sp_wr together with start: load wins, start dropped
    sp_wr = 1'b1; sp_wdata = 16'h1111; start = 1'b1; op = OP_POP;
    @(posedge clk); #1;
    sp_wr = 1'b0; start = 1'b0; sp_m = 16'h1111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("drop_start_busy", {31'd0, busy}, 32'd0);
    end
    chk("drop_start_sp", {16'd0, sp}, 32'h00001111);
    @(posedge clk); #1;

    // Reset in cycle 5 of a PUSH
    issue(OP_PUSH, 1'b0, 16'hA55A);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    bus_q.delete();
    done_q.delete();
    sp_m = 16'h0000;
    #1;
    chk("mid_rst_sp", {16'd0, sp}, 32'd0);
    chk("mid_rst_ctrl", {27'd0, rd, wr, busy, done, wb_valid}, 32'd0);
    chk("mid_rst_data", {dout, adr[7:0], wb_data}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      chk("post_rst_quiet", {29'd0, wr, busy, done}, 32'd0);
    end

    @(posedge clk); #1;
    chk("bus_q_empty", bus_q.size(), 32'd0);
    chk("done_q_empty", done_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
